// File: rtl/mp_result_packer_pkg.sv
// Shared types and constants for the mixed-precision result packer.
// Element precision encodings, lane widths and the packer FSM state type.
package mp_result_packer_pkg;

  typedef enum logic [1:0] {
    PREC_INT8 = 2'b00,
    PREC_FP16 = 2'b01,
    PREC_FP32 = 2'b10,
    PREC_RSVD = 2'b11
  } prec_e;

  localparam int W_INT8     = 8;
  localparam int W_FP16     = 16;
  localparam int W_FP32     = 32;
  localparam int W_ACC_INT8 = 32;
  localparam int W_WORD     = 32;

  typedef enum logic {
    PK_IDLE = 1'b0,
    PK_FILL = 1'b1
  } pk_state_e;

  // The reserved encoding packs like FP32.
  function automatic logic [2:0] lanes_per_word(input prec_e p);
    case (p)
      PREC_INT8: return 3'd4;
      PREC_FP16: return 3'd2;
      default:   return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mp_result_packer_sat.sv
// Signed 32-bit accumulator to INT8 clamp; the flag marks a clamped value.
module mp_sat_int8
  import mp_result_packer_pkg::*;
(
  input  logic [W_ACC_INT8-1:0] acc_in,
  output logic [W_INT8-1:0]     sat_out,
  output logic                  sat_flag
);

  logic signed [W_ACC_INT8-1:0] acc_s;

  assign acc_s = acc_in;

  always_comb begin
    sat_out  = acc_in[W_INT8-1:0];
    sat_flag = 1'b0;
    if (acc_s > 32'sd127) begin
      sat_out  = 8'h7F;
      sat_flag = 1'b1;
    end else if (acc_s < -32'sd128) begin
      sat_out  = 8'h80;
      sat_flag = 1'b1;
    end
  end

endmodule

// File: rtl/mp_result_packer.sv
// Packs INT8/FP16/FP32 elements into 32-bit words with byte enables.
// One fill register plus one output register; in_ready drops only when both hold a finished word.
module mp_result_packer
  import mp_result_packer_pkg::*;
#(
  parameter bit SAT_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       prec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [3:0]       out_be,
  output logic             out_last,
  output logic [CNT_W-1:0] sat_count,
  output logic             err_prec,
  output logic             dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid, once raised, holds its payload stable until the transfer.

  pk_state_e         state_q, state_d;
  prec_e             prec_q, prec_d;
  logic [1:0]        lane_q, lane_d;
  logic [W_WORD-1:0] fill_data_q, fill_data_d;
  logic [3:0]        fill_be_q, fill_be_d;
  logic              fill_last_q, fill_last_d;
  logic              pend_q, pend_d;
  logic              out_valid_q, out_valid_d;
  logic [W_WORD-1:0] out_data_q, out_data_d;
  logic [3:0]        out_be_q, out_be_d;
  logic              out_last_q, out_last_d;
  logic [CNT_W-1:0]  sat_count_q, sat_count_d;
  logic              err_prec_q, err_prec_d;

  prec_e             cur_prec;
  logic [2:0]        lanes;
  logic [2:0]        lanes_m1;
  logic [1:0]        last_lane;
  logic [W_INT8-1:0] sat_byte;
  logic              sat_hit;
  logic [W_INT8-1:0] int8_byte;
  logic [W_WORD-1:0] lane_word;
  logic [3:0]        lane_be;
  logic [W_WORD-1:0] new_data;
  logic [3:0]        new_be;
  logic              out_free;
  logic              accept;
  logic              complete;

  mp_sat_int8 u_sat (
    .acc_in   (in_data),
    .sat_out  (sat_byte),
    .sat_flag (sat_hit)
  );

  // Precision is live from the input only for the element that opens a packet.
  assign cur_prec  = (state_q == PK_IDLE) ? prec_e'(prec) : prec_q;
  assign lanes     = lanes_per_word(cur_prec);
  assign lanes_m1  = lanes - 3'd1;
  assign last_lane = lanes_m1[1:0];
  assign int8_byte = SAT_EN ? sat_byte : in_data[W_INT8-1:0];

  assign out_free  = !out_valid_q || out_ready;
  assign in_ready  = !rst && !(pend_q && !out_free);
  assign accept    = in_valid && in_ready;
  assign complete  = accept && ((lane_q == last_lane) || in_last);

  always_comb begin
    lane_word = '0;
    lane_be   = '0;
    case (cur_prec)
      PREC_INT8: begin
        lane_word = {24'b0, int8_byte} << {lane_q, 3'b000};
        lane_be   = 4'b0001 << lane_q;
      end
      PREC_FP16: begin
        lane_word = {16'b0, in_data[W_FP16-1:0]} << {lane_q[0], 4'b0000};
        lane_be   = 4'b0011 << {lane_q[0], 1'b0};
      end
      default: begin
        lane_word = in_data[W_FP32-1:0];
        lane_be   = 4'hF;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    prec_d      = prec_q;
    lane_d      = lane_q;
    fill_data_d = fill_data_q;
    fill_be_d   = fill_be_q;
    fill_last_d = fill_last_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_be_d    = out_be_q;
    out_last_d  = out_last_q;
    sat_count_d = sat_count_q;
    err_prec_d  = err_prec_q;
    new_data    = '0;
    new_be      = '0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    // A stalled finished word leaves the fill register as soon as the output frees up.
    if (pend_q && out_free) begin
      out_valid_d = 1'b1;
      out_data_d  = fill_data_q;
      out_be_d    = fill_be_q;
      out_last_d  = fill_last_q;
      pend_d      = 1'b0;
      fill_data_d = '0;
      fill_be_d   = '0;
      fill_last_d = 1'b0;
    end

    if (accept) begin
      new_data = fill_data_d | lane_word;
      new_be   = fill_be_d | lane_be;
      if (state_q == PK_IDLE) begin
        state_d = PK_FILL;
        prec_d  = prec_e'(prec);
        if (prec == 2'b11) err_prec_d = 1'b1;
      end
      if (SAT_EN && sat_hit && (cur_prec == PREC_INT8) && (sat_count_q != '1))
        sat_count_d = sat_count_q + 1'b1;
      if (complete) begin
        lane_d = '0;
        if (in_last) state_d = PK_IDLE;
        if (out_free && !pend_q) begin
          out_valid_d = 1'b1;
          out_data_d  = new_data;
          out_be_d    = new_be;
          out_last_d  = in_last;
          fill_data_d = '0;
          fill_be_d   = '0;
          fill_last_d = 1'b0;
        end else begin
          pend_d      = 1'b1;
          fill_data_d = new_data;
          fill_be_d   = new_be;
          fill_last_d = in_last;
        end
      end else begin
        lane_d      = lane_q + 2'd1;
        fill_data_d = new_data;
        fill_be_d   = new_be;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PK_IDLE;
      prec_q      <= PREC_INT8;
      lane_q      <= '0;
      fill_data_q <= '0;
      fill_be_q   <= '0;
      fill_last_q <= 1'b0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_be_q    <= '0;
      out_last_q  <= 1'b0;
      sat_count_q <= '0;
      err_prec_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prec_q      <= prec_d;
      lane_q      <= lane_d;
      fill_data_q <= fill_data_d;
      fill_be_q   <= fill_be_d;
      fill_last_q <= fill_last_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_be_q    <= out_be_d;
      out_last_q  <= out_last_d;
      sat_count_q <= sat_count_d;
      err_prec_q  <= err_prec_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_be    = out_be_q;
  assign out_last  = out_last_q;
  assign sat_count = sat_count_q;
  assign err_prec  = err_prec_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mp_result_packer.sv
// Bench for mp_result_packer: directed cases with literal expectations plus a randomized run,
// all output words scored against a packet-level model of the packing rules.
module tb_mp_result_packer;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic [1:0]       prec;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [3:0]       out_be;
  logic             out_last;
  logic [CNT_W-1:0] sat_count;
  logic             err_prec;
  logic             dbg_state;

  mp_result_packer #(.SAT_EN(1'b1), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .prec      (prec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_be    (out_be),
    .out_last  (out_last),
    .sat_count (sat_count),
    .err_prec  (err_prec),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_words  = 0;
  int or_mode  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard: {last, be, data}
  logic [36:0] exp_q[$];

  // Reference model state
  logic             m_open;
  logic [1:0]       m_prec;
  int               m_lane;
  logic [31:0]      m_word;
  logic [3:0]       m_be;
  logic [CNT_W-1:0] m_sat;
  logic             m_err;
  logic             hold_v;
  logic [36:0]      hold_w;

  task automatic model_clear();
    exp_q.delete();
    m_open = 1'b0;
    m_prec = 2'b00;
    m_lane = 0;
    m_word = '0;
    m_be   = '0;
    m_sat  = '0;
    m_err  = 1'b0;
    hold_v = 1'b0;
  endtask

  task automatic model_accept(input logic [1:0] p, input logic [31:0] d, input logic l);
    int lanes;
    int w;
    int v;
    logic [31:0] val;
    if (!m_open) begin
      m_open = 1'b1;
      m_prec = p;
      if (p == 2'b11) m_err = 1'b1;
    end
    lanes = (m_prec == 2'b00) ? 4 : (m_prec == 2'b01) ? 2 : 1;
    w     = 32 / lanes;
    v     = d;
    if (lanes == 4) begin
      if (v > 127) begin
        val = 32'h7F;
        if (m_sat != '1) m_sat = m_sat + 1'b1;
      end else if (v < -128) begin
        val = 32'h80;
        if (m_sat != '1) m_sat = m_sat + 1'b1;
      end else begin
        val = d & 32'hFF;
      end
    end else if (lanes == 2) begin
      val = d & 32'hFFFF;
    end else begin
      val = d;
    end
    m_word = m_word | (val << (m_lane * w));
    m_be   = m_be | (4'((1 << (w / 8)) - 1) << (m_lane * (w / 8)));
    m_lane++;
    if (m_lane == lanes || l) begin
      exp_q.push_back({l, m_be, m_word});
      m_word = '0;
      m_be   = '0;
      m_lane = 0;
      if (l) m_open = 1'b0;
    end
  endtask

  // Compare process: all outputs sampled on the falling edge
  always @(negedge clk) begin
    logic [36:0] e;
    if (rst) begin
      model_clear();
    end else begin
      check("sat_count", 64'(sat_count), 64'(m_sat));
      check("err_prec", 64'(err_prec), 64'(m_err));
      if (hold_v) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_word", {27'b0, out_last, out_be, out_data}, {27'b0, hold_w});
      end
      hold_v = out_valid && !out_ready;
      hold_w = {out_last, out_be, out_data};
      if (!in_ready) check("in_ready_drop", {62'b0, out_valid, out_ready}, 64'b10);
      if (out_valid && out_ready) begin
        n_words++;
        if (exp_q.size() == 0) begin
          check("unexpected_word", {27'b0, out_last, out_be, out_data}, 64'hDEAD_0000_0000);
        end else begin
          e = exp_q.pop_front();
          check("out_word", {27'b0, out_last, out_be, out_data}, {27'b0, e});
        end
      end
      if (in_valid && in_ready) model_accept(prec, in_data, in_last);
    end
  end

  // out_ready driver: 0 = held high, 1 = toggle each cycle, 2 = random
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !out_ready;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Driver tasks (called at posedge + 1)
  task automatic send_elem(input logic [1:0] p, input logic [31:0] d, input logic l);
    int n;
    n        = 0;
    in_valid = 1'b1;
    prec     = p;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("handshake", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = 1'($urandom_range(0, 1));
    prec     = 2'($urandom_range(0, 3));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      in_last  = 1'($urandom_range(0, 1));
      prec     = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n       = 0;
    or_mode = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b1;
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out", {27'b0, out_valid, out_last, out_be, out_data}, 64'd0);
    check("rst_sat_err", {47'b0, err_prec, sat_count}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    logic [31:0] d;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    prec     = 2'b00;
    #1;
    do_reset();

    // INT8 full word, latency 1
    send_elem(2'b00, 32'd1, 1'b0);
    send_elem(2'b00, 32'd2, 1'b0);
    send_elem(2'b00, 32'd3, 1'b0);
    send_elem(2'b00, 32'd4, 1'b1);
    check("int8_valid", 64'(out_valid), 64'd1);
    check("int8_word", {27'b0, out_last, out_be, out_data}, {27'b0, 1'b1, 4'hF, 32'h04030201});
    idle(2);

    // INT8 saturation, partial word
    send_elem(2'b00, 32'd300, 1'b0);
    send_elem(2'b00, -32'sd500, 1'b0);
    send_elem(2'b00, 32'd5, 1'b1);
    check("sat_word", {27'b0, out_last, out_be, out_data}, {27'b0, 1'b1, 4'h7, 32'h0005807F});
    check("sat_count_2", 64'(sat_count), 64'd2);
    idle(2);

    // FP16 lanes
    send_elem(2'b01, 32'hFFFF3C00, 1'b0);
    send_elem(2'b01, 32'h0000C000, 1'b1);
    check("fp16_word", {28'b0, out_be, out_data}, {28'b0, 4'hF, 32'hC0003C00});
    idle(2);

    // FP32 back-to-back with out_ready toggling
    base    = n_words;
    or_mode = 1;
    for (int i = 0; i < 8; i++) send_elem(2'b10, $urandom, (i == 7));
    drain();
    check("fp32_word_count", 64'(n_words - base), 64'd8);
    idle(2);

    // Precision locked mid-packet, then reserved encoding
    send_elem(2'b01, 32'h00001111, 1'b0);
    send_elem(2'b00, 32'h00002222, 1'b0);
    check("lock_word0", 64'(out_data), 64'h22221111);
    send_elem(2'b00, 32'h00003333, 1'b1);
    check("lock_word1", {28'b0, out_be, out_data}, {28'b0, 4'h3, 32'h00003333});
    check("err_before", 64'(err_prec), 64'd0);
    send_elem(2'b11, 32'hDEADBEEF, 1'b1);
    check("rsvd_word", {28'b0, out_be, out_data}, {28'b0, 4'hF, 32'hDEADBEEF});
    check("err_prec_set", 64'(err_prec), 64'd1);
    idle(2);

    // Reset mid-packet discards partial lanes
    send_elem(2'b00, 32'd7, 1'b0);
    send_elem(2'b00, 32'd8, 1'b0);
    do_reset();
    send_elem(2'b00, 32'd9, 1'b1);
    check("post_rst_word", {28'b0, out_be, out_data}, {28'b0, 4'h1, 32'h00000009});
    drain();

    // Randomized run: gaps, random precision, random backpressure
    or_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) d = $urandom;
      else d = 32'($urandom_range(0, 600)) - 32'd300;
      send_elem(2'($urandom_range(0, 3)), d, (i == 399) || ($urandom_range(0, 4) == 0));
    end
    idle(1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
